// File: rtl/byte_transmitter_pkg.sv
// Shared encodings and sizing for the I2C slave byte transmitter.
package byte_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRIVE = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int BIT_CNT_W  = 3;
  localparam int HOLD_MAX   = 15;
  localparam int HOLD_CNT_W = $clog2(HOLD_MAX + 1);

endpackage

// File: rtl/byte_transmitter.sv
// I2C slave-side byte transmitter: shifts a byte MSB first onto open-drain SDA, HOLD_CYCLES after each SCL fall, then samples ACK.
// Optional NACK counter output enabled by defining I2C_TX_NACK_COUNT_EN.
module byte_transmitter
  import byte_transmitter_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_data,
  input  logic       abort,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic       busy,
  output logic       done,
`ifdef I2C_TX_NACK_COUNT_EN
  output logic       nack,
  output logic [7:0] nack_count
`else
  output logic       nack
`endif
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LD = HOLD_CNT_W'(HOLD_CYCLES);

  state_t                 state;
  state_t                 state_nxt;
  logic [7:0]             shreg;
  logic [BIT_CNT_W-1:0]   bitcnt;
  logic [HOLD_CNT_W-1:0]  holdcnt;
  logic                   hold_last;
  logic                   rise_ok;
  logic                   ack_taken;

  assign hold_last = (holdcnt == HOLD_CNT_W'(1));
  // A coincident fall means the rise belongs to a glitch; only a clean rise counts.
  assign rise_ok   = scl_rise & ~scl_fall;
  assign ack_taken = (state == ACK) & rise_ok & ~abort;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load) state_nxt = HOLD;
        HOLD:    if (hold_last) state_nxt = DRIVE;
        DRIVE:   if (scl_fall) state_nxt = (bitcnt != '0) ? HOLD : ACK;
        ACK:     if (rise_ok) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_drive_low <= 1'b0;
      done          <= 1'b0;
      nack          <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      holdcnt       <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        sda_drive_low <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_drive_low <= 1'b0;
            if (load) begin
              shreg   <= tx_data;
              bitcnt  <= '1;
              holdcnt <= HOLD_LD;
            end
          end
          HOLD: begin
            holdcnt <= holdcnt - 1'b1;
            if (hold_last) sda_drive_low <= ~shreg[7];
          end
          DRIVE: begin
            if (scl_fall) begin
              holdcnt <= HOLD_LD;
              if (bitcnt != '0) begin
                bitcnt <= bitcnt - 1'b1;
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          ACK: begin
            // Keep the last bit held for HOLD_CYCLES after the final fall, then release for the master's ACK.
            if (holdcnt != '0) begin
              holdcnt <= holdcnt - 1'b1;
              if (hold_last) sda_drive_low <= 1'b0;
            end
            if (rise_ok) begin
              nack          <= sda_in;
              done          <= 1'b1;
              sda_drive_low <= 1'b0;
            end
          end
          default: sda_drive_low <= 1'b0;
        endcase
      end
    end
  end

`ifdef I2C_TX_NACK_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                        nack_count <= '0;
    else if (ack_taken && sda_in && nack_count != '1) nack_count <= nack_count + 1'b1;
  end
`endif

endmodule
